// File: rtl/load_use_scoreboard.sv
// Per-register load-use countdown for a 7-stage pipe (IF ID EX MEM1 MEM2 MEM3 WB).
// A load's result forwards only from MEM3/WB, so ID stalls until the destination's countdown permits.
module load_use_scoreboard #(
  parameter int NUM_REGS    = 32,
  parameter int IDX_W       = 5,
  parameter int LOAD_STALL  = 2,
  parameter int STORE_SLACK = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic                id_en_rs1,
  input  logic [IDX_W-1:0]    id_rs1,
  input  logic                id_en_rs2,
  input  logic [IDX_W-1:0]    id_rs2,
  input  logic                id_en_memw,
  input  logic                id_en_regw,
  input  logic                id_en_memr,
  input  logic [IDX_W-1:0]    id_rd,
  input  logic                flush_id,
  input  logic                freeze,
  output logic                stall_id,
  output logic [2:0]          stall_cause,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [31:0]         stall_cnt
);

  localparam int CNT_W = $clog2(LOAD_STALL + 1);
  localparam logic [CNT_W-1:0] LOAD_C  = CNT_W'(LOAD_STALL);
  localparam logic [CNT_W-1:0] SLACK_C = CNT_W'(STORE_SLACK);

  logic [CNT_W-1:0] r_cnt [NUM_REGS];
  logic [31:0]      r_stall_cnt;

  logic [CNT_W-1:0] w_cnt_rs1;
  logic [CNT_W-1:0] w_cnt_rs2;
  logic [2:0]       w_cause;
  logic             w_stall;
  logic             w_issue;

  assign w_cnt_rs1 = r_cnt[id_rs1];
  assign w_cnt_rs2 = r_cnt[id_rs2];

  // Checks see the count before this cycle's decrement/load.
  assign w_cause[0] = id_valid & id_en_rs1  & (id_rs1 != '0) & (w_cnt_rs1 != '0);
  assign w_cause[1] = id_valid & id_en_rs2  & (id_rs2 != '0) & (w_cnt_rs2 != '0);
  assign w_cause[2] = id_valid & id_en_memw & (id_rs2 != '0) & (w_cnt_rs2 > SLACK_C);
  assign w_stall    = |w_cause;
  assign w_issue    = id_valid & ~w_stall & ~flush_id & ~freeze;

  assign stall_id    = w_stall;
  assign stall_cause = w_cause;
  assign stall_cnt   = r_stall_cnt;

  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_vec[i] = (r_cnt[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= '0;
      end
      r_stall_cnt <= '0;
    end else if (!freeze) begin
      // Entry 0 is left untouched so x0 never looks busy.
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_issue && id_en_regw && (id_rd == IDX_W'(i))) begin
          r_cnt[i] <= id_en_memr ? LOAD_C : '0;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

endmodule
